// File: rtl/draw_pkg.sv
// Shared types for the draw pipeline arbiters.
//   arb_state_t : quad arbiter FSM state encoding
//   quad_t      : one quad slot as packed on quad_in (x0 in the LSBs)
//   DEF_CORDW / DEF_COLRW : default coordinate and colour widths
package draw_pkg;

    localparam int DEF_CORDW = 16;
    localparam int DEF_COLRW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    // First member lands in the MSBs, so y3 leads and x0 ends up at bit 0.
    typedef struct packed {
        logic signed [DEF_CORDW-1:0] y3;
        logic signed [DEF_CORDW-1:0] x3;
        logic signed [DEF_CORDW-1:0] y2;
        logic signed [DEF_CORDW-1:0] x2;
        logic signed [DEF_CORDW-1:0] y1;
        logic signed [DEF_CORDW-1:0] x1;
        logic signed [DEF_CORDW-1:0] y0;
        logic signed [DEF_CORDW-1:0] x0;
    } quad_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index that has highest priority this round
//   win     : one-hot winner (zero when no request)
//   win_idx : binary index of the winner
//   any     : at least one request is set
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_idx,
    output logic          any
);

    int j;

    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise the
        // paths where no request matches would infer latches.
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        j       = 0;
        // Scan ptr, ptr+1, ... wrapping at N; the first set request wins.
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[IW'(j)]) begin
                any          = 1'b1;
                win[IW'(j)]  = 1'b1;
                win_idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/quad_arbiter.sv
// Round-robin arbiter sharing one draw_quad engine between NREQ producers.
//   clk, rstn        : clock, synchronous active-low reset
//   req              : level request per requester
//   quad_in, colr_in : per-requester quad vertices / colour, sampled at grant
//   hold             : blocks new grants (in-flight quad still completes)
//   grant            : one-hot owner of the engine
//   ack              : one-cycle completion pulse to the owner
//   eng_start        : one-cycle start pulse to draw_quad
//   eng_x0..eng_y3, eng_colr : latched quad handed to draw_quad
//   eng_done         : draw_quad completion pulse
//   busy             : engine owned by a requester
module quad_arbiter
    import draw_pkg::*;
#(
    parameter int CORDW = DEF_CORDW,
    parameter int COLRW = DEF_COLRW,
    parameter int NREQ  = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*8*CORDW-1:0]   quad_in,
    input  logic [NREQ*COLRW-1:0]     colr_in,
    input  logic                      hold,
    output logic [NREQ-1:0]           grant,
    output logic [NREQ-1:0]           ack,
    output logic                      eng_start,
    output logic signed [CORDW-1:0]   eng_x0,
    output logic signed [CORDW-1:0]   eng_y0,
    output logic signed [CORDW-1:0]   eng_x1,
    output logic signed [CORDW-1:0]   eng_y1,
    output logic signed [CORDW-1:0]   eng_x2,
    output logic signed [CORDW-1:0]   eng_y2,
    output logic signed [CORDW-1:0]   eng_x3,
    output logic signed [CORDW-1:0]   eng_y3,
    output logic [COLRW-1:0]          eng_colr,
    input  logic                      eng_done,
    output logic                      busy
);

    localparam int IW = $clog2(NREQ);

    arb_state_t            state;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         owner;
    logic [8*CORDW-1:0]    eng_quad;

    logic [NREQ-1:0]       win;
    logic [IW-1:0]         win_idx;
    logic                  any;
    logic [8*CORDW-1:0]    sel_quad;
    logic [COLRW-1:0]      sel_colr;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    assign sel_quad = quad_in[int'(win_idx)*8*CORDW +: 8*CORDW];
    assign sel_colr = colr_in[int'(win_idx)*COLRW +: COLRW];

    assign eng_x0 = eng_quad[0*CORDW +: CORDW];
    assign eng_y0 = eng_quad[1*CORDW +: CORDW];
    assign eng_x1 = eng_quad[2*CORDW +: CORDW];
    assign eng_y1 = eng_quad[3*CORDW +: CORDW];
    assign eng_x2 = eng_quad[4*CORDW +: CORDW];
    assign eng_y2 = eng_quad[5*CORDW +: CORDW];
    assign eng_x3 = eng_quad[6*CORDW +: CORDW];
    assign eng_y3 = eng_quad[7*CORDW +: CORDW];

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            grant     <= '0;
            ack       <= '0;
            eng_start <= 1'b0;
            busy      <= 1'b0;
            eng_quad  <= '0;
            eng_colr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hold && any) begin
                        eng_quad  <= sel_quad;
                        eng_colr  <= sel_colr;
                        grant     <= win;
                        owner     <= win_idx;
                        busy      <= 1'b1;
                        eng_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    // eng_done cannot be valid yet; the engine only just started.
                    eng_start <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        ack   <= grant;
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;
                        state <= ACK;
                    end
                end
                ACK: begin
                    // Forced gap cycle: the acked requester gets time to drop req.
                    ack   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
